// File: rtl/v_dma_pkg.sv
// Shared types and helpers for the DMA channel sequencer: beat sizes, channel
// states, and the natural-alignment beat size selector.
package v_dma_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_t;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_CMD   = 3'd1,
        RD_WAIT  = 3'd2,
        WR_FETCH = 3'd3,
        WR_CMD   = 3'd4,
        WR_WAIT  = 3'd5,
        FLUSH    = 3'd6,
        DONE     = 3'd7
    } ch_state_t;

    // Largest naturally-aligned beat that fits in n bytes starting at addr.
    function automatic size_t sz_sel(input logic [1:0] addr, input logic [31:0] n);
        size_t s;
        if ((addr == 2'b00) && (n >= 32'd4)) begin
            s = SZ_WORD;
        end else if ((addr[0] == 1'b0) && (n >= 32'd2)) begin
            s = SZ_HALF;
        end else begin
            s = SZ_BYTE;
        end
        return s;
    endfunction

    function automatic logic [2:0] size_bytes(input size_t s);
        logic [2:0] b;
        case (s)
            SZ_WORD: b = 3'd4;
            SZ_HALF: b = 3'd2;
            SZ_BYTE: b = 3'd1;
            default: b = 3'd1;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/v_ch_ctrl.sv
// Per-channel DMA sequencer: alternates read phases that fill the byte-lane
// FIFO with write phases that drain it, one bus command outstanding at a time.
module v_ch_ctrl
    import v_dma_pkg::*;
#(
    parameter int BUFFER_SIZE = 2,
    parameter int LEN_W       = 16
) (
    input  logic             clk,
    input  logic             areset,
    input  logic             start_i,
    input  logic [31:0]      src_addr_i,
    input  logic [31:0]      dst_addr_i,
    input  logic [LEN_W-1:0] len_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic             cmd_valid_o,
    input  logic             cmd_ready_i,
    output logic             cmd_write_o,
    output logic [31:0]      cmd_addr_o,
    output logic [1:0]       cmd_size_o,
    output logic [31:0]      cmd_wdata_o,
    input  logic             rsp_valid_i,
    input  logic             rsp_err_i,
    input  logic [31:0]      rsp_rdata_i,
    output logic             fifo_write_o,
    output logic             fifo_read_o,
    output logic [1:0]       fifo_size_o,
    output logic [1:0]       fifo_offset_o,
    output logic [31:0]      fifo_wdata_o,
    input  logic [31:0]      fifo_rdata_i
);

    localparam int FIFO_BYTES = 4 * BUFFER_SIZE;
    localparam int LVL_W      = $clog2(FIFO_BYTES + 1);

    ch_state_t        state_r, state_s;
    logic [31:0]      src_r, src_s;
    logic [31:0]      dst_r, dst_s;
    logic [LEN_W-1:0] rd_rem_r, rd_rem_s;
    logic [LVL_W-1:0] level_r, level_s;
    size_t            size_r, size_s;
    logic             busy_r, busy_s;
    logic             done_r, done_s;
    logic             err_r, err_s;

    logic [31:0]      room_s;
    logic [31:0]      rd_n_s;
    size_t            rd_sz_s;
    size_t            wr_sz_s;
    logic [2:0]       beat_bytes_s;
    logic [LEN_W-1:0] rd_rem_dec_s;
    logic [LVL_W-1:0] level_inc_s;
    logic [LVL_W-1:0] level_dec_s;

    // Read beats are limited by both the bytes left and the free FIFO space.
    assign room_s       = 32'(FIFO_BYTES) - 32'(level_r);
    assign rd_n_s       = (32'(rd_rem_r) < room_s) ? 32'(rd_rem_r) : room_s;
    assign rd_sz_s      = sz_sel(src_r[1:0], rd_n_s);
    assign wr_sz_s      = sz_sel(dst_r[1:0], 32'(level_r));
    assign beat_bytes_s = size_bytes(size_r);
    assign rd_rem_dec_s = rd_rem_r - LEN_W'(beat_bytes_s);
    assign level_inc_s  = level_r + LVL_W'(beat_bytes_s);
    assign level_dec_s  = level_r - LVL_W'(beat_bytes_s);

    assign busy_o = busy_r;
    assign done_o = done_r;
    assign err_o  = err_r;

    // Next-state, datapath updates and per-state bus/FIFO controls.
    always_comb begin
        state_s       = state_r;
        src_s         = src_r;
        dst_s         = dst_r;
        rd_rem_s      = rd_rem_r;
        level_s       = level_r;
        size_s        = size_r;
        busy_s        = busy_r;
        done_s        = 1'b0;
        err_s         = err_r;
        cmd_valid_o   = 1'b0;
        cmd_write_o   = 1'b0;
        cmd_addr_o    = 32'd0;
        cmd_size_o    = 2'd0;
        cmd_wdata_o   = 32'd0;
        fifo_write_o  = 1'b0;
        fifo_read_o   = 1'b0;
        fifo_size_o   = 2'd0;
        fifo_offset_o = 2'd0;
        fifo_wdata_o  = 32'd0;

        case (state_r)
            IDLE: begin
                if (start_i) begin
                    src_s    = src_addr_i;
                    dst_s    = dst_addr_i;
                    rd_rem_s = len_i;
                    level_s  = {LVL_W{1'b0}};
                    err_s    = 1'b0;
                    busy_s   = 1'b1;
                    state_s  = (len_i == {LEN_W{1'b0}}) ? DONE : RD_CMD;
                end else begin
                    state_s = IDLE;
                end
            end
            RD_CMD: begin
                cmd_valid_o = 1'b1;
                cmd_addr_o  = src_r;
                cmd_size_o  = rd_sz_s;
                if (cmd_ready_i) begin
                    size_s  = rd_sz_s;
                    state_s = RD_WAIT;
                end else begin
                    state_s = RD_CMD;
                end
            end
            RD_WAIT: begin
                if (rsp_valid_i) begin
                    if (rsp_err_i) begin
                        err_s    = 1'b1;
                        rd_rem_s = {LEN_W{1'b0}};
                        state_s  = FLUSH;
                    end else begin
                        fifo_write_o  = 1'b1;
                        fifo_size_o   = size_r;
                        fifo_offset_o = src_r[1:0];
                        fifo_wdata_o  = rsp_rdata_i;
                        src_s         = src_r + 32'(beat_bytes_s);
                        rd_rem_s      = rd_rem_dec_s;
                        level_s       = level_inc_s;
                        if ((rd_rem_dec_s != {LEN_W{1'b0}}) && (32'(level_inc_s) < 32'(FIFO_BYTES))) begin
                            state_s = RD_CMD;
                        end else begin
                            state_s = WR_FETCH;
                        end
                    end
                end else begin
                    state_s = RD_WAIT;
                end
            end
            WR_FETCH: begin
                fifo_read_o   = 1'b1;
                fifo_size_o   = wr_sz_s;
                fifo_offset_o = dst_r[1:0];
                size_s        = wr_sz_s;
                state_s       = WR_CMD;
            end
            WR_CMD: begin
                cmd_valid_o = 1'b1;
                cmd_write_o = 1'b1;
                cmd_addr_o  = dst_r;
                cmd_size_o  = size_r;
                cmd_wdata_o = fifo_rdata_i;
                if (cmd_ready_i) begin
                    state_s = WR_WAIT;
                end else begin
                    state_s = WR_CMD;
                end
            end
            WR_WAIT: begin
                if (rsp_valid_i) begin
                    level_s = level_dec_s;
                    if (rsp_err_i) begin
                        err_s    = 1'b1;
                        rd_rem_s = {LEN_W{1'b0}};
                        state_s  = FLUSH;
                    end else begin
                        dst_s = dst_r + 32'(beat_bytes_s);
                        if (level_dec_s != {LVL_W{1'b0}}) begin
                            state_s = WR_FETCH;
                        end else if (rd_rem_r != {LEN_W{1'b0}}) begin
                            state_s = RD_CMD;
                        end else begin
                            state_s = DONE;
                        end
                    end
                end else begin
                    state_s = WR_WAIT;
                end
            end
            FLUSH: begin
                // Byte-wise drain keeps the FIFO lane pointers in step for the next transfer.
                if (level_r != {LVL_W{1'b0}}) begin
                    fifo_read_o = 1'b1;
                    level_s     = level_r - LVL_W'(1'b1);
                    state_s     = (level_r == LVL_W'(1'b1)) ? DONE : FLUSH;
                end else begin
                    state_s = DONE;
                end
            end
            DONE: begin
                done_s  = 1'b1;
                busy_s  = 1'b0;
                state_s = IDLE;
            end
            default: begin
                busy_s  = 1'b0;
                state_s = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            state_r  <= IDLE;
            src_r    <= 32'd0;
            dst_r    <= 32'd0;
            rd_rem_r <= {LEN_W{1'b0}};
            level_r  <= {LVL_W{1'b0}};
            size_r   <= SZ_BYTE;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            err_r    <= 1'b0;
        end else begin
            state_r  <= state_s;
            src_r    <= src_s;
            dst_r    <= dst_s;
            rd_rem_r <= rd_rem_s;
            level_r  <= level_s;
            size_r   <= size_s;
            busy_r   <= busy_s;
            done_r   <= done_s;
            err_r    <= err_s;
        end
    end

endmodule

// File: tb/tb_v_ch_ctrl.sv
// Bench for v_ch_ctrl: emulates the bus slave and byte-lane FIFO, and checks
// commands and memory contents against a beat-list model of the transfer.
module tb_v_ch_ctrl;
    import v_dma_pkg::*;

    localparam int BUFFER_SIZE = 2;
    localparam int LEN_W       = 16;
    localparam int FIFO_BYTES  = 4 * BUFFER_SIZE;

    logic clk, areset, start_i;
    logic [31:0] src_addr_i, dst_addr_i;
    logic [LEN_W-1:0] len_i;
    logic busy_o, done_o, err_o;
    logic cmd_valid_o, cmd_ready_i, cmd_write_o;
    logic [31:0] cmd_addr_o, cmd_wdata_o;
    logic [1:0] cmd_size_o;
    logic rsp_valid_i, rsp_err_i;
    logic [31:0] rsp_rdata_i;
    logic fifo_write_o, fifo_read_o;
    logic [1:0] fifo_size_o, fifo_offset_o;
    logic [31:0] fifo_wdata_o, fifo_rdata_i;

    v_ch_ctrl #(.BUFFER_SIZE(BUFFER_SIZE), .LEN_W(LEN_W)) dut (
        .clk(clk), .areset(areset), .start_i(start_i),
        .src_addr_i(src_addr_i), .dst_addr_i(dst_addr_i), .len_i(len_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
        .cmd_valid_o(cmd_valid_o), .cmd_ready_i(cmd_ready_i), .cmd_write_o(cmd_write_o),
        .cmd_addr_o(cmd_addr_o), .cmd_size_o(cmd_size_o), .cmd_wdata_o(cmd_wdata_o),
        .rsp_valid_i(rsp_valid_i), .rsp_err_i(rsp_err_i), .rsp_rdata_i(rsp_rdata_i),
        .fifo_write_o(fifo_write_o), .fifo_read_o(fifo_read_o),
        .fifo_size_o(fifo_size_o), .fifo_offset_o(fifo_offset_o),
        .fifo_wdata_o(fifo_wdata_o), .fifo_rdata_i(fifo_rdata_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed { logic w; logic [31:0] a; logic [1:0] s; } beat_t;

    int checks = 0;
    int errors = 0;
    beat_t exp_q[$];
    logic [7:0] fq[$];
    logic [7:0] wmem [logic [31:0]];
    int n_exp, done_cnt, cmd_cnt, frd_cnt, frd_b0_cnt, rd_cnt, underflow, err_rd_n;
    int bp_lo = 0, bp_hi = 0, bp_cur = 0, hold = 0;
    bit out_pend = 0, out_wr = 0, prev_stall = 0;
    int out_rd_idx = 0, lat = 0;
    logic [31:0] out_addr;
    logic [67:0] prev_cmd;
    time st_t, done_t;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] src_byte(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    // Largest power of two that fits in n and divides the address.
    function automatic int pick(input logic [31:0] a, input int n);
        int bt = 4;
        while ((bt > n) || ((int'(a[1:0]) % bt) != 0)) bt = bt / 2;
        return bt;
    endfunction

    function automatic logic [1:0] code(input int bt);
        return (bt == 4) ? 2'd2 : ((bt == 2) ? 2'd1 : 2'd0);
    endfunction

    // Expected beat list: fill FIFO with reads, then drain it fully with writes.
    task automatic build(input logic [31:0] s, input logic [31:0] d, input int len);
        int rd = len;
        int lvl = 0;
        int n, bt;
        logic [31:0] a = s;
        logic [31:0] b = d;
        exp_q.delete();
        while (rd > 0) begin
            while ((rd > 0) && (lvl < FIFO_BYTES)) begin
                n  = (rd < FIFO_BYTES - lvl) ? rd : FIFO_BYTES - lvl;
                bt = pick(a, n);
                exp_q.push_back('{w: 1'b0, a: a, s: code(bt)});
                a = a + 32'(bt); rd -= bt; lvl += bt;
            end
            while (lvl > 0) begin
                bt = pick(b, lvl);
                exp_q.push_back('{w: 1'b1, a: b, s: code(bt)});
                b = b + 32'(bt); lvl -= bt;
            end
        end
    endtask

    // Environment: bus slave with backpressure/latency plus the byte-lane FIFO.
    initial begin
        logic [31:0] word, base, ai, nrd;
        beat_t eb;
        cmd_ready_i = 1'b0; rsp_valid_i = 1'b0; rsp_err_i = 1'b0;
        rsp_rdata_i = 32'd0; fifo_rdata_i = 32'd0;
        forever begin
            @(negedge clk);
            cmd_ready_i = (hold >= bp_cur);
            if (out_pend && (lat == 0)) begin
                base = out_addr & ~32'h3;
                for (int k = 0; k < 4; k++) word[8*k +: 8] = src_byte(base + 32'(k));
                rsp_valid_i = 1'b1;
                rsp_err_i   = !out_wr && (out_rd_idx == err_rd_n);
                rsp_rdata_i = word;
            end else begin
                rsp_valid_i = 1'b0;
                rsp_err_i   = 1'b0;
                rsp_rdata_i = $urandom;
            end
            #1;
            if (!areset) begin
                out_pend = 0; prev_stall = 0; hold = 0;
                fq.delete(); fifo_rdata_i = 32'd0;
            end else begin
                if (done_o) begin done_cnt++; done_t = $time; end
                chk("fifo_rw_exclusive", {31'd0, fifo_read_o & fifo_write_o}, 32'd0);
                if (prev_stall)
                    chk("cmd_stable", {cmd_valid_o, cmd_write_o, cmd_addr_o, cmd_size_o, cmd_wdata_o},
                        {1'b1, prev_cmd[66:0]});
                if (rsp_valid_i) out_pend = 0;
                else if (out_pend) lat--;
                if (cmd_valid_o && cmd_ready_i) begin
                    cmd_cnt++;
                    eb = (exp_q.size() > 0) ? exp_q.pop_front() : '{w: 1'b1, a: 32'hFFFF_FFFF, s: 2'b11};
                    chk("cmd_beat", {cmd_write_o, cmd_addr_o, cmd_size_o}, eb);
                    if (cmd_write_o) begin
                        for (int k = 0; k < (1 << cmd_size_o); k++) begin
                            ai = cmd_addr_o + 32'(k);
                            wmem[ai] = cmd_wdata_o[8*(int'(cmd_addr_o[1:0]) + k) +: 8];
                        end
                    end else begin
                        rd_cnt++;
                        out_rd_idx = rd_cnt;
                    end
                    out_pend = 1; out_wr = cmd_write_o; out_addr = cmd_addr_o;
                    lat = $urandom_range(0, 2);
                    hold = 0; prev_stall = 0;
                    bp_cur = $urandom_range(bp_lo, bp_hi);
                end else if (cmd_valid_o) begin
                    hold++; prev_stall = 1;
                    prev_cmd = {cmd_valid_o, cmd_write_o, cmd_addr_o, cmd_size_o, cmd_wdata_o};
                end else begin
                    prev_stall = 0;
                end
                if (fifo_write_o) begin
                    for (int k = 0; k < (1 << fifo_size_o); k++)
                        fq.push_back(fifo_wdata_o[8*(int'(fifo_offset_o) + k) +: 8]);
                end
                if (fifo_read_o) begin
                    frd_cnt++;
                    if ((fifo_size_o == 2'd0) && (fifo_offset_o == 2'd0)) frd_b0_cnt++;
                    nrd = 32'd0;
                    for (int k = 0; k < (1 << fifo_size_o); k++) begin
                        if (fq.size() > 0) nrd[8*(int'(fifo_offset_o) + k) +: 8] = fq.pop_front();
                        else underflow++;
                    end
                    fifo_rdata_i = nrd;
                end
            end
        end
    end

    task automatic run_xfer(input logic [31:0] s, input logic [31:0] d, input int len,
                            input int blo, input int bhi, input int err_n, input bit poke);
        int n = 0;
        logic [31:0] ai;
        build(s, d, len);
        n_exp = exp_q.size();
        wmem.delete();
        done_cnt = 0; cmd_cnt = 0; frd_cnt = 0; frd_b0_cnt = 0; rd_cnt = 0; underflow = 0;
        bp_lo = blo; bp_hi = bhi; bp_cur = $urandom_range(blo, bhi); hold = 0; err_rd_n = err_n;
        @(negedge clk);
        start_i = 1'b1; src_addr_i = s; dst_addr_i = d; len_i = LEN_W'(len);
        st_t = $time;
        @(negedge clk);
        start_i = 1'b0;
        #2;
        chk("busy_after_start", {31'd0, busy_o}, 32'd1);
        chk("err_clear_on_start", {31'd0, err_o}, 32'd0);
        if (poke) begin
            repeat (3) @(negedge clk);
            start_i = 1'b1; src_addr_i = 32'hDEAD_0000; dst_addr_i = 32'hBEEF_0000; len_i = 16'd3;
            repeat (3) @(negedge clk);
            start_i = 1'b0;
        end
        while ((done_cnt == 0) && (n < 3000)) begin
            @(negedge clk);
            n++;
        end
        #2;
        chk("done_seen", done_cnt, 32'd1);
        @(negedge clk);
        #2;
        chk("done_once", done_cnt, 32'd1);
        chk("busy_after_done", {31'd0, busy_o}, 32'd0);
        chk("err_o", {31'd0, err_o}, {31'd0, err_n != 0});
        chk("fifo_underflow", underflow, 32'd0);
        chk("fifo_empty", fq.size(), 32'd0);
        if (err_n == 0) begin
            chk("cmd_count", cmd_cnt, n_exp);
            for (int i = 0; i < len; i++) begin
                ai = d + 32'(i);
                chk("mem_byte", wmem.exists(ai) ? {1'b0, wmem[ai]} : 9'h100, {1'b0, src_byte(s + 32'(i))});
            end
        end
    endtask

    initial begin
        areset = 1'b0; start_i = 1'b0;
        src_addr_i = 32'd0; dst_addr_i = 32'd0; len_i = 16'd0;
        repeat (3) @(negedge clk);
        #2;
        chk("reset_outputs", {busy_o, done_o, err_o, cmd_valid_o, cmd_write_o, cmd_addr_o, cmd_size_o,
                              cmd_wdata_o, fifo_write_o, fifo_read_o, fifo_size_o, fifo_offset_o, fifo_wdata_o},
            128'd0);
        @(negedge clk);
        areset = 1'b1;
        @(negedge clk);

        run_xfer(32'h0000_0000, 32'h0000_0100, 16, 0, 0, 0, 1'b0);
        run_xfer(32'h0000_1001, 32'h0000_2002, 5, 0, 2, 0, 1'b0);

        run_xfer(32'h0000_0040, 32'h0000_0080, 0, 0, 0, 0, 1'b0);
        chk("zero_len_latency", 64'(done_t - st_t), 64'd21);
        chk("zero_len_no_cmd", cmd_cnt, 32'd0);

        run_xfer(32'h0000_0200, 32'h0000_0300, 16, 5, 5, 0, 1'b1);
        run_xfer(32'h0000_1003, 32'h0000_2001, 11, 5, 5, 0, 1'b0);

        run_xfer(32'h0000_4000, 32'h0000_5000, 8, 0, 1, 2, 1'b0);
        chk("flush_reads", frd_cnt, 32'd4);
        chk("flush_byte_reads", frd_b0_cnt, 32'd4);
        chk("err_read_cmds", cmd_cnt, 32'd2);
        run_xfer(32'h0000_6000, 32'h0000_7000, 4, 0, 1, 0, 1'b0);

        run_xfer(32'hFFFF_FFFD, 32'hFFFF_FFFE, 7, 0, 2, 0, 1'b0);

        for (int r = 0; r < 8; r++)
            run_xfer(32'h0000_3000 + $urandom_range(0, 255), 32'h0000_8000 + $urandom_range(0, 255),
                     $urandom_range(1, 40), 0, 2, 0, 1'b0);

        build(32'h0000_0000, 32'h0000_0100, 16);
        @(negedge clk);
        start_i = 1'b1; src_addr_i = 32'h0; dst_addr_i = 32'h100; len_i = 16'd16;
        @(negedge clk);
        start_i = 1'b0;
        repeat (6) @(negedge clk);
        areset = 1'b0;
        #2;
        chk("midreset_idle", {busy_o, cmd_valid_o, fifo_read_o, fifo_write_o}, 4'd0);
        @(negedge clk);
        areset = 1'b1;
        run_xfer(32'h0000_0A02, 32'h0000_0B01, 13, 0, 2, 0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
